psum_collector: RTL and testbench

//  Downstream of one PE column. Takes the partial sums that leave the top PE of the column,

---
 rtl/psum_collector_pkg.sv | 27 ++
 rtl/psum_collector_fifo.sv | 50 +++++
 rtl/psum_collector.sv | 158 +++++++++++++++
 tb/tb_psum_collector.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_collector_pkg.sv
// Shared types for the PE-column psum collector: psum type, ofmap packet layout
// and the collector FSM states.
package psum_collector_pkg;

  localparam int PSUM_W      = 16;
  localparam int OF_W        = 8;
  localparam int OFMAP_LANES = 4;
  localparam int LANE_W      = $clog2(OFMAP_LANES);
  localparam int IDX_W       = 5;
  localparam int CNT_W       = 3;

  typedef logic signed [PSUM_W-1:0] PSUM_DATA_SIZE;

  typedef struct packed {
    logic                                valid;
    logic [IDX_W-1:0]                    packet_idx;
    logic [CNT_W-1:0]                    cnt;
    logic [OFMAP_LANES-1:0][OF_W-1:0]    data;
  } OFMAP_PACKET;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } collector_state_e;

endpackage

// File: rtl/psum_collector_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a synchronous clear empties it.
module psum_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers decide what is readable.
  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/psum_collector.sv
// Collects column psums, requantises them and packs four per ofmap packet.
// Build option PSUM_RELU_EN: ReLU + unsigned saturation instead of signed saturation.
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int PSUM_W     = 16,
  parameter int OF_W       = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SHIFT_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               change_mode,
  input  logic               flush,
  input  logic [SHIFT_W-1:0] shift_amt,
  input  logic [PSUM_W-1:0]  psum_in,
  input  logic               psum_valid_in,
  output logic               psum_ack_out,
  output OFMAP_PACKET        ofmap_pkt,
  input  logic               ofmap_ready,
  output logic               busy
);

  collector_state_e r_state;
  collector_state_e w_state_nxt;

  logic                             r_valid;
  logic [IDX_W-1:0]                 r_idx;
  logic [CNT_W-1:0]                 r_cnt;
  logic [OFMAP_LANES-1:0][OF_W-1:0] r_data;

  logic                             w_valid_nxt;
  logic [IDX_W-1:0]                 w_idx_nxt;
  logic [CNT_W-1:0]                 w_cnt_nxt;
  logic [OFMAP_LANES-1:0][OF_W-1:0] w_data_nxt;

  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic [PSUM_W-1:0]        w_fifo_head;
  logic signed [PSUM_W-1:0] w_head;
  logic signed [PSUM_W-1:0] w_shifted;
  logic [OF_W-1:0]          w_req;
  logic                     w_accept;
  logic                     w_pop;
  logic                     w_xfer;
  logic                     w_finalize;

  // Accept only on a registered not-full so ofmap_ready never reaches psum_ack_out.
  assign w_accept     = psum_valid_in & ~w_fifo_full & rst_n;
  assign psum_ack_out = w_accept;

  assign w_xfer     = r_valid & ofmap_ready;
  assign w_pop      = ~w_fifo_empty & (~r_valid | ofmap_ready);
  assign w_finalize = (r_state == ST_FLUSH) & w_fifo_empty & ~w_accept & ~r_valid;

  psum_fifo #(
    .WIDTH (PSUM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (change_mode),
    .i_push  (w_accept & ~change_mode),
    .i_pop   (w_pop & ~change_mode),
    .i_data  (psum_in),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_head    = w_fifo_head;
  assign w_shifted = w_head >>> shift_amt;

`ifdef PSUM_RELU_EN
  localparam logic signed [PSUM_W-1:0] L_UMAX = PSUM_W'((1 << OF_W) - 1);

  always_comb begin
    w_req = w_shifted[OF_W-1:0];
    if (w_shifted < 0)           w_req = '0;
    else if (w_shifted > L_UMAX) w_req = L_UMAX[OF_W-1:0];
  end
`else
  localparam logic signed [PSUM_W-1:0] L_SMAX = PSUM_W'((1 << (OF_W - 1)) - 1);
  localparam logic signed [PSUM_W-1:0] L_SMIN = -PSUM_W'(1 << (OF_W - 1));

  always_comb begin
    w_req = w_shifted[OF_W-1:0];
    if (w_shifted > L_SMAX)      w_req = L_SMAX[OF_W-1:0];
    else if (w_shifted < L_SMIN) w_req = L_SMIN[OF_W-1:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = flush ? ST_FLUSH : ST_RUN;
      ST_RUN:   if (flush) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (w_finalize) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (change_mode) w_state_nxt = ST_IDLE;
  end

  // A transfer clears the packer first so a same-cycle pop refills lane 0.
  always_comb begin
    w_valid_nxt = r_valid;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    if (change_mode) begin
      w_valid_nxt = 1'b0;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
      w_data_nxt  = '0;
    end else begin
      if (w_xfer) begin
        w_valid_nxt = 1'b0;
        w_idx_nxt   = r_idx + 1'b1;
        w_cnt_nxt   = '0;
        w_data_nxt  = '0;
      end
      if (w_pop) begin
        w_data_nxt[w_cnt_nxt[LANE_W-1:0]] = w_req;
        w_cnt_nxt   = w_cnt_nxt + 1'b1;
        w_valid_nxt = (w_cnt_nxt == CNT_W'(OFMAP_LANES));
      end else if (w_finalize && (r_cnt != '0)) begin
        w_valid_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign ofmap_pkt.valid      = r_valid;
  assign ofmap_pkt.packet_idx = r_idx;
  assign ofmap_pkt.cnt        = r_cnt;
  assign ofmap_pkt.data       = r_data;

  assign busy = (r_state != ST_IDLE) | ~w_fifo_empty | (r_cnt != '0);

endmodule

// File: tb/tb_psum_collector.sv
// Scoreboard bench for psum_collector: directed psum streams with hand-computed packets.
module tb_psum_collector;
  import psum_collector_pkg::*;

  typedef struct {
    logic [4:0]      idx;
    logic [2:0]      cnt;
    logic [3:0][7:0] data;
  } exp_pkt_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        change_mode;
  logic        flush;
  logic [3:0]  shift_amt;
  logic [15:0] psum_in;
  logic        psum_valid_in;
  logic        psum_ack_out;
  OFMAP_PACKET ofmap_pkt;
  logic        ofmap_ready;
  logic        busy;

  exp_pkt_t expQ[$];
  exp_pkt_t monExp;
  int numCompared   = 0;
  int numMismatched = 0;

  always #5 clk = ~clk;

  psum_collector #(
    .PSUM_W     (16),
    .OF_W       (8),
    .FIFO_DEPTH (4),
    .SHIFT_W    (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .change_mode   (change_mode),
    .flush         (flush),
    .shift_amt     (shift_amt),
    .psum_in       (psum_in),
    .psum_valid_in (psum_valid_in),
    .psum_ack_out  (psum_ack_out),
    .ofmap_pkt     (ofmap_pkt),
    .ofmap_ready   (ofmap_ready),
    .busy          (busy)
  );

  // Monitor: every packet transfer is checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && ofmap_pkt.valid && ofmap_ready) begin
      numCompared++;
      if (expQ.size() == 0) begin
        numMismatched++;
        $display("[TB] FAIL unexpected_pkt: got idx=%0d cnt=%0d data=%h, required no packet",
                 ofmap_pkt.packet_idx, ofmap_pkt.cnt, ofmap_pkt.data);
      end else begin
        monExp = expQ.pop_front();
        if (ofmap_pkt.packet_idx !== monExp.idx || ofmap_pkt.cnt !== monExp.cnt ||
            ofmap_pkt.data !== monExp.data) begin
          numMismatched++;
          $display("[TB] FAIL pkt: got idx=%0d cnt=%0d data=%h, required idx=%0d cnt=%0d data=%h",
                   ofmap_pkt.packet_idx, ofmap_pkt.cnt, ofmap_pkt.data,
                   monExp.idx, monExp.cnt, monExp.data);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] required);
    numCompared++;
    if (actual !== required) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  task automatic expectPkt(input int idx, input int cnt, input int d0, input int d1,
                           input int d2, input int d3);
    exp_pkt_t e;
    e.idx     = 5'(idx);
    e.cnt     = 3'(cnt);
    e.data[0] = 8'(d0);
    e.data[1] = 8'(d1);
    e.data[2] = 8'(d2);
    e.data[3] = 8'(d3);
    expQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One psum through the valid/ack handshake, bounded.
  task automatic applyStimulus(input int value);
    bit accepted = 1'b0;
    psum_in       = 16'(value);
    psum_valid_in = 1'b1;
    for (int c = 0; c < 200 && !accepted; c++) begin
      @(negedge clk);
      if (psum_ack_out) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    psum_valid_in = 1'b0;
    if (!accepted) begin
      numCompared++;
      numMismatched++;
      $display("[TB] FAIL ack_timeout: psum %0d got no ack, required ack within 200 cycles", value);
    end
  endtask

  task automatic waitDrain(input int budget);
    for (int c = 0; c < budget && expQ.size() != 0; c++) tick();
    checkOutput("drain_outstanding", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int k;
    int lowRun;

    rst_n         = 1'b0;
    change_mode   = 1'b0;
    flush         = 1'b0;
    shift_amt     = 4'd0;
    psum_in       = 16'd0;
    psum_valid_in = 1'b0;
    ofmap_ready   = 1'b1;
    #3;
    checkOutput("reset_ack", 64'(psum_ack_out), 64'd0);
    checkOutput("reset_pkt", 64'(ofmap_pkt), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Plain pass-through
    expectPkt(0, 4, 10, 20, 30, 40);
    applyStimulus(10);
    applyStimulus(20);
    applyStimulus(30);
    applyStimulus(40);
    waitDrain(50);

    // Shift and saturation
    shift_amt = 4'd2;
`ifdef PSUM_RELU_EN
    expectPkt(1, 4, 0, 75, 0, 250);
`else
    expectPkt(1, 4, -75, 75, -1, 127);
`endif
    applyStimulus(-300);
    applyStimulus(300);
    applyStimulus(-1);
    applyStimulus(1000);
    waitDrain(50);
    checkOutput("busy_in_run", 64'(busy), 64'd1);

    // Output stall: packer full plus FIFO full before ack drops
    shift_amt   = 4'd0;
    ofmap_ready = 1'b0;
    expectPkt(2, 4, 1, 2, 3, 4);
    expectPkt(3, 4, 5, 6, 7, 8);
    expectPkt(4, 4, 9, 10, 11, 12);
    k      = 0;
    lowRun = 0;
    psum_valid_in = 1'b1;
    psum_in       = 16'(k + 1);
    for (int c = 0; c < 60 && lowRun < 4 && k < 12; c++) begin
      @(negedge clk);
      if (psum_ack_out) begin
        k++;
        lowRun = 0;
      end else begin
        lowRun++;
      end
      @(posedge clk);
      #1;
      psum_in = 16'(k + 1);
    end
    checkOutput("accepts_before_stall", 64'(k), 64'd8);
    checkOutput("ack_low_when_full", 64'(psum_ack_out), 64'd0);
    checkOutput("pkt_held_valid", 64'(ofmap_pkt.valid), 64'd1);
    checkOutput("pkt_held_cnt", 64'(ofmap_pkt.cnt), 64'd4);
    psum_valid_in = 1'b0;
    ofmap_ready   = 1'b1;
    for (int v = k + 1; v <= 12; v++) applyStimulus(v);
    waitDrain(100);

    // Flush of a partial packet
    expectPkt(5, 3, 1, 2, 3, 0);
    applyStimulus(1);
    applyStimulus(2);
    applyStimulus(3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    waitDrain(50);
    repeat (3) tick();
    checkOutput("busy_after_flush", 64'(busy), 64'd0);

    // Flush with nothing buffered emits nothing
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    checkOutput("busy_idle_flush", 64'(busy), 64'd0);
    repeat (3) tick();

    // 33 packets, packet_idx wraps 31 -> 0 at the 27th
    for (int p = 0; p < 33; p++) begin
      expectPkt((6 + p) % 32, 4, p, p + 10, p + 20, p + 30);
      applyStimulus(p);
      applyStimulus(p + 10);
      applyStimulus(p + 20);
      applyStimulus(p + 30);
    end
    waitDrain(400);

    // change_mode drops a half-filled packet and restarts the index
    applyStimulus(100);
    applyStimulus(101);
    repeat (3) tick();
    change_mode = 1'b1;
    tick();
    change_mode = 1'b0;
    checkOutput("busy_after_mode", 64'(busy), 64'd0);
    expectPkt(0, 4, 40, 41, 42, 43);
    applyStimulus(40);
    applyStimulus(41);
    applyStimulus(42);
    applyStimulus(43);
    waitDrain(50);

    // Asynchronous reset mid-stream with valid held
    psum_valid_in = 1'b1;
    psum_in       = 16'd7;
    tick();
    psum_in = 16'd8;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_ack", 64'(psum_ack_out), 64'd0);
    checkOutput("async_rst_pkt", 64'(ofmap_pkt), 64'd0);
    checkOutput("async_rst_busy", 64'(busy), 64'd0);
    psum_valid_in = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    expectPkt(0, 4, 5, 6, 7, 8);
    applyStimulus(5);
    applyStimulus(6);
    applyStimulus(7);
    applyStimulus(8);
    waitDrain(50);

    repeat (5) tick();
    checkOutput("queue_empty_at_end", 64'(expQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
